// File: rtl/ex_stage_pipe_reg_pkg.sv
// Shared types and helpers for the execute-stage pipeline register.
// Default payload width = uop + imm(32) + rj/rk/rd(15).
package ex_stage_pipe_reg_pkg;

    localparam int WIDTH_UOP     = 81;
    localparam int DEF_PAYLOAD_W = WIDTH_UOP + 32 + 15;
    localparam int MAX_LANES     = 8;

    typedef logic [MAX_LANES-1:0] lane_mask_t;

    // True when any lane older than `lane` raised an exception.
    function automatic logic older_excp(input lane_mask_t excp, input int lane);
        logic r;
        r = 1'b0;
        for (int j = 0; j < MAX_LANES; j++) begin
            if (j < lane) r = r | excp[j];
        end
        return r;
    endfunction

endpackage

// File: rtl/ex_stage_pipe_reg_skid_slot.sv
// Single-entry holding register for one bundle: valid/excp/payload with load and clear.
// Clear zeroes valid and excp but leaves payload (don't-care when empty).
module ex_stage_pipe_reg_skid_slot #(
    parameter int LANES     = 2,
    parameter int PAYLOAD_W = 128
) (
    input  logic                       clk,
    input  logic                       aresetn,
    input  logic                       load_i,
    input  logic                       clear_i,
    input  logic [LANES-1:0]           valid_i,
    input  logic [LANES-1:0]           excp_i,
    input  logic [LANES*PAYLOAD_W-1:0] payload_i,
    output logic [LANES-1:0]           valid_o,
    output logic [LANES-1:0]           excp_o,
    output logic [LANES*PAYLOAD_W-1:0] payload_o
);

    logic [LANES-1:0]           valid_q;
    logic [LANES-1:0]           excp_q;
    logic [LANES*PAYLOAD_W-1:0] payload_q;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            valid_q   <= '0;
            excp_q    <= '0;
            payload_q <= '0;
        end else if (clear_i) begin
            valid_q <= '0;
            excp_q  <= '0;
        end else if (load_i) begin
            valid_q   <= valid_i;
            excp_q    <= excp_i;
            payload_q <= payload_i;
        end
    end

    assign valid_o   = valid_q;
    assign excp_o    = excp_q;
    assign payload_o = payload_q;

endmodule

// File: rtl/ex_stage_pipe_reg.sv
// Execute sub-stage pipeline register: 1-cycle latency, full throughput, main + skid slot.
// in_ready depends only on skid occupancy, so out_ready never reaches it combinationally.
module ex_stage_pipe_reg
    import ex_stage_pipe_reg_pkg::*;
#(
    parameter int LANES     = 2,
    parameter int PAYLOAD_W = DEF_PAYLOAD_W,
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       aresetn,
    input  logic                       flush_in,
    output logic                       flush_out,
    input  logic [LANES-1:0]           in_valid,
    input  logic [LANES-1:0]           in_excp,
    input  logic [LANES*PAYLOAD_W-1:0] in_payload,
    output logic                       in_ready,
    output logic [LANES-1:0]           out_valid,
    output logic [LANES-1:0]           out_excp,
    output logic [LANES*PAYLOAD_W-1:0] out_payload,
    input  logic                       out_ready,
    output logic [CNT_W-1:0]           stall_cnt
);

    logic [LANES-1:0]           cap_valid;
    logic [LANES-1:0]           main_valid, main_excp;
    logic [LANES-1:0]           skid_valid, skid_excp;
    logic [LANES*PAYLOAD_W-1:0] main_payload, skid_payload;
    logic [LANES-1:0]           main_valid_d, main_excp_d;
    logic [LANES*PAYLOAD_W-1:0] main_payload_d;

    logic main_occ, skid_full, in_fire, out_fire, main_take;
    logic main_load, main_clear, skid_load, skid_clear;

    logic             flush_q;
    logic [CNT_W-1:0] stall_q, stall_d;

    // Younger lanes behind an excepting lane are squashed before capture.
    always_comb begin
        cap_valid = '0;
        for (int i = 0; i < LANES; i++) begin
            cap_valid[i] = in_valid[i] & ~older_excp(lane_mask_t'(in_excp), i);
        end
    end

    always_comb begin
        main_occ   = |main_valid;
        skid_full  = |skid_valid;
        in_fire    = (|in_valid) & ~skid_full;
        out_fire   = main_occ & out_ready;
        main_take  = ~main_occ | out_fire;

        main_load  = ~flush_in & main_take & (skid_full | in_fire);
        main_clear = flush_in | (main_take & ~skid_full & ~in_fire);
        skid_load  = ~flush_in & in_fire & main_occ & ~out_ready;
        skid_clear = flush_in | (skid_full & main_take);

        main_valid_d   = skid_full ? skid_valid   : cap_valid;
        main_excp_d    = skid_full ? skid_excp    : in_excp;
        main_payload_d = skid_full ? skid_payload : in_payload;
    end

    ex_stage_pipe_reg_skid_slot #(
        .LANES     (LANES),
        .PAYLOAD_W (PAYLOAD_W)
    ) u_main (
        .clk       (clk),
        .aresetn   (aresetn),
        .load_i    (main_load),
        .clear_i   (main_clear),
        .valid_i   (main_valid_d),
        .excp_i    (main_excp_d),
        .payload_i (main_payload_d),
        .valid_o   (main_valid),
        .excp_o    (main_excp),
        .payload_o (main_payload)
    );

    ex_stage_pipe_reg_skid_slot #(
        .LANES     (LANES),
        .PAYLOAD_W (PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .aresetn   (aresetn),
        .load_i    (skid_load),
        .clear_i   (skid_clear),
        .valid_i   (cap_valid),
        .excp_i    (in_excp),
        .payload_i (in_payload),
        .valid_o   (skid_valid),
        .excp_o    (skid_excp),
        .payload_o (skid_payload)
    );

    always_comb begin
        stall_d = stall_q;
        if (main_occ && !out_ready && stall_q != {CNT_W{1'b1}}) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            flush_q <= 1'b0;
            stall_q <= '0;
        end else begin
            flush_q <= flush_in;
            stall_q <= stall_d;
        end
    end

    assign in_ready    = ~skid_full;
    assign out_valid   = main_valid;
    assign out_excp    = main_excp;
    assign out_payload = main_payload;
    assign flush_out   = flush_q;
    assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_ex_stage_pipe_reg.sv
// Randomized bench for ex_stage_pipe_reg against a bundle-queue reference model.
module tb_ex_stage_pipe_reg;

    localparam int LANES = 2;
    localparam int PW    = 32;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic                  clk = 1'b0;
    logic                  aresetn;
    logic                  flush_in;
    logic                  flush_out;
    logic [LANES-1:0]      in_valid;
    logic [LANES-1:0]      in_excp;
    logic [LANES*PW-1:0]   in_payload;
    logic                  in_ready;
    logic [LANES-1:0]      out_valid;
    logic [LANES-1:0]      out_excp;
    logic [LANES*PW-1:0]   out_payload;
    logic                  out_ready;
    logic [CW-1:0]         stall_cnt;

    always #5 clk = ~clk;

    ex_stage_pipe_reg #(
        .LANES     (LANES),
        .PAYLOAD_W (PW),
        .CNT_W     (CW)
    ) dut (
        .clk         (clk),
        .aresetn     (aresetn),
        .flush_in    (flush_in),
        .flush_out   (flush_out),
        .in_valid    (in_valid),
        .in_excp     (in_excp),
        .in_payload  (in_payload),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_excp    (out_excp),
        .out_payload (out_payload),
        .out_ready   (out_ready),
        .stall_cnt   (stall_cnt)
    );

    typedef struct {
        logic [1:0]  v;
        logic [1:0]  e;
        logic [63:0] p;
    } bund_t;

    bund_t mq[$];
    int    m_cnt;
    logic  m_fo;
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Lanes strictly younger than the oldest excepting lane lose their valid.
    function automatic logic [1:0] kill(input logic [1:0] v, input logic [1:0] e);
        int k;
        logic [1:0] r;
        k = LANES;
        for (int i = LANES - 1; i >= 0; i--) if (e[i]) k = i;
        r = v;
        for (int i = 0; i < LANES; i++) if (i > k) r[i] = 1'b0;
        return r;
    endfunction

    task automatic check_outputs();
        chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
        chk("flush_out", 64'(flush_out), 64'(m_fo));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        if (mq.size() > 0) begin
            chk("out_valid", 64'(out_valid), 64'(mq[0].v));
            chk("out_excp", 64'(out_excp), 64'(mq[0].e));
            chk("out_payload", 64'(out_payload), mq[0].p);
        end else begin
            chk("out_valid_empty", 64'(out_valid), 64'd0);
            chk("out_excp_empty", 64'(out_excp), 64'd0);
        end
    endtask

    task automatic step(input logic [1:0] v, input logic [1:0] e, input logic [63:0] p,
                        input logic rdy, input logic fl, input logic rn, output logic acc);
        logic  pre_ready;
        bund_t b;
        in_valid   = v;
        in_excp    = e;
        in_payload = p;
        out_ready  = rdy;
        flush_in   = fl;
        aresetn    = rn;
        pre_ready  = (mq.size() < 2);
        acc        = 1'b0;
        @(posedge clk);
        if (!rn) begin
            mq.delete();
            m_cnt = 0;
            m_fo  = 1'b0;
        end else begin
            if (mq.size() > 0 && !rdy && m_cnt < CMAX) m_cnt++;
            m_fo = fl;
            if (fl) begin
                mq.delete();
            end else begin
                acc = (v != 2'b00) && pre_ready;
                if (mq.size() > 0 && rdy) void'(mq.pop_front());
                if (acc) begin
                    b.v = kill(v, e);
                    b.e = e;
                    b.p = p;
                    if (b.v != 2'b00) mq.push_back(b);
                end
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        logic        acc;
        logic [63:0] pa, pb, pc, rp;
        logic [1:0]  rv, re;
        int          n;

        mq.delete();
        m_cnt = 0;
        m_fo  = 1'b0;

        // Reset state
        step(2'b11, 2'b00, 64'hdead_beef_cafe_f00d, 1'b1, 1'b1, 1'b0, acc);
        step(2'b00, 2'b00, 64'h0, 1'b1, 1'b0, 1'b0, acc);
        chk("rst_payload", out_payload, 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Streaming
        for (int i = 0; i < 4; i++) begin
            step(2'b11, 2'b00, {32'h22 + 32'(i), 32'h11 + 32'(i)}, 1'b1, 1'b0, 1'b1, acc);
            chk("stream_payload", out_payload, {32'h22 + 32'(i), 32'h11 + 32'(i)});
        end
        chk("stream_stall", 64'(stall_cnt), 64'd0);

        // Back-pressure: A in main, B in skid, C held upstream until accepted
        pa = 64'hAAAA_0001_AAAA_0002;
        pb = 64'hBBBB_0001_BBBB_0002;
        pc = 64'hCCCC_0001_CCCC_0002;
        step(2'b00, 2'b00, 64'h0, 1'b1, 1'b0, 1'b1, acc);
        step(2'b11, 2'b00, pa, 1'b0, 1'b0, 1'b1, acc);
        step(2'b11, 2'b00, pb, 1'b0, 1'b0, 1'b1, acc);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        step(2'b11, 2'b00, pc, 1'b0, 1'b0, 1'b1, acc);
        chk("bp_hold_a", out_payload, pa);
        n = 0;
        do begin
            step(2'b11, 2'b00, pc, 1'b1, 1'b0, 1'b1, acc);
            n++;
        end while (!acc && n < 10);
        chk("bp_c_accepted", 64'(acc), 64'd1);
        for (int i = 0; i < 3; i++) step(2'b00, 2'b00, 64'h0, 1'b1, 1'b0, 1'b1, acc);

        // Lane kill
        step(2'b11, 2'b01, 64'h1234_5678_9abc_def0, 1'b1, 1'b0, 1'b1, acc);
        chk("kill01_valid", 64'(out_valid), 64'd1);
        chk("kill01_excp", 64'(out_excp), 64'd1);
        step(2'b11, 2'b10, 64'h0fed_cba9_8765_4321, 1'b1, 1'b0, 1'b1, acc);
        chk("kill10_valid", 64'(out_valid), 64'd3);
        chk("kill10_excp", 64'(out_excp), 64'd2);

        // Flush mid-stall
        step(2'b11, 2'b00, pa, 1'b0, 1'b0, 1'b1, acc);
        step(2'b11, 2'b00, pb, 1'b0, 1'b0, 1'b1, acc);
        step(2'b11, 2'b00, pc, 1'b0, 1'b1, 1'b1, acc);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        chk("flush_out_hi", 64'(flush_out), 64'd1);
        step(2'b00, 2'b00, 64'h0, 1'b1, 1'b0, 1'b1, acc);
        chk("flush_out_lo", 64'(flush_out), 64'd0);

        // Reset mid-operation
        step(2'b11, 2'b00, pa, 1'b0, 1'b0, 1'b1, acc);
        step(2'b11, 2'b00, pb, 1'b0, 1'b0, 1'b1, acc);
        step(2'b11, 2'b00, pc, 1'b0, 1'b0, 1'b1, acc);
        step(2'b11, 2'b00, pc, 1'b0, 1'b0, 1'b0, acc);
        chk("rstmid_valid", 64'(out_valid), 64'd0);
        chk("rstmid_payload", out_payload, 64'd0);
        chk("rstmid_stall", 64'(stall_cnt), 64'd0);

        // Saturation
        step(2'b11, 2'b00, pa, 1'b0, 1'b0, 1'b1, acc);
        for (int i = 0; i < 20; i++) step(2'b00, 2'b00, 64'h0, 1'b0, 1'b0, 1'b1, acc);
        chk("sat_stall", 64'(stall_cnt), 64'(CMAX));

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            rv = 2'($urandom);
            re = 2'($urandom) & rv;
            if ($urandom_range(0, 3) == 0) re = 2'b00;
            rp = {$urandom, $urandom};
            step(rv, re, rp, ($urandom_range(0, 9) < 6), ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 79) != 0), acc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
